register_file_param: RTL and testbench
======================================

REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: register width in bits, a multiple of 8, at least 8.
REQ-002 The block SHALL have parameter DEPTH, default 32: number of registers, at least 2.
REQ-003 The block SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 The block SHALL have parameter ZERO_REG, default 1: 1 = register 0 reads as zero and ignores writes.
REQ-005 The block SHALL have derived constant ADDR_W = clog2(DEPTH), not overridable.
REQ-006 The block SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port Rst_n  input  1  reset; asynchronous, active-low.
REQ-008 The block SHALL have port WE  input  1  write enable.
REQ-009 The block SHALL have port WAddr  input  ADDR_W  write address.
REQ-010 The block SHALL have port WData  input  DATA_W  write data.
REQ-011 The block SHALL have port WStrb  input  DATA_W/8  byte-lane write strobes; bit i covers WData[8i+7:8i].
REQ-012 The block SHALL have port RAddr1  input  ADDR_W  read port 1 address.
REQ-013 The block SHALL have port RAddr2  input  ADDR_W  read port 2 address.
REQ-014 The block SHALL have port RData1  output  DATA_W  read port 1 data.
REQ-015 The block SHALL have port RData2  output  DATA_W  read port 2 data.

Function
REQ-016 On a rising Clk edge with Rst_n=1, WE=1 and WAddr<DEPTH, the addressed register SHALL update every byte lane whose WStrb bit is 1 and keep every other lane unchanged.
REQ-017 WE=1 with WStrb all zero SHALL leave the register unchanged.
REQ-018 With ZERO_REG=1, writes to address 0 SHALL be ignored and RDataN for address 0 SHALL be all zeros, including under bypass.
REQ-019 Writes to WAddr>=DEPTH SHALL be ignored; reads from RAddrN>=DEPTH SHALL return all zeros.
REQ-020 Reads SHALL be combinational: RDataN reflects the stored value of RAddrN in the same cycle, with zero cycles of latency.
REQ-021 With BYPASS=1, when WE=1 and WAddr==RAddrN for a valid, writable address, RDataN SHALL equal the post-write merged value (strobed lanes from WData, others from storage) in the same cycle.
REQ-022 With BYPASS=0, RDataN SHALL show the pre-write value until the edge and the new value after it.
REQ-023 Both read ports SHALL be independent; equal addresses on both ports SHALL give identical data.
REQ-024 Writes SHALL take effect exactly one edge after being presented; back-to-back writes to the same address SHALL leave the last write's lanes winning.

Reset
REQ-025 Rst_n=0 SHALL clear every register to zero immediately, without waiting for Clk.
REQ-026 While Rst_n=0, RData1 and RData2 SHALL be zero and writes SHALL be ignored.
REQ-027 Reset asserted mid-write SHALL leave the target register at zero; the first edge after Rst_n rises SHALL accept writes normally.

Structure
REQ-028 A shared package SHALL hold the defaults: DATA_W=32 and DEPTH=32; byte-lane width 8; and a clog2 function.
REQ-029 Storage SHALL use one sub-module, register_nbit (DATA_W-wide register with byte strobes and async active-low clear), instantiated DEPTH times, or DEPTH-1 times when ZERO_REG=1.
REQ-030 Write decode, bypass merge and read muxes SHALL live in register_file_param.

Verification
REQ-031 The bench SHALL cover reset: Rst_n=0 for 3 ns then release, read all addresses -> every RData = 0x00000000.
REQ-032 The bench SHALL cover a full write: WE=1, WAddr=5, WData=0xFFFFFFFF, WStrb=4'b1111, then read RAddr1=5 -> 0xFFFFFFFF; then write WData=0x12345678 with WStrb=4'b0101 -> 0xFF34FF78.
REQ-033 The bench SHALL cover the zero register: write 0xDEADBEEF to address 0 with ZERO_REG=1 -> RData1 = 0 with RAddr1=0, both during the write cycle and after it.
REQ-034 The bench SHALL cover bypass: with register 7 = 0xAAAAAAAA, present WE=1, WAddr=7, WData=0x0000F0F0, WStrb=4'b0011, RAddr2=7 -> same cycle RData2 = 0xAAAAF0F0 for BYPASS=1 and 0xAAAAAAAA for BYPASS=0.
REQ-035 The bench SHALL cover async reset mid-operation: register 3 = 0x11111111, pull Rst_n low between edges -> RData1 with RAddr1=3 goes to 0 before the next Clk edge; a write one edge after release is stored.
REQ-036 The bench SHALL cover a non-default configuration: DATA_W=16, DEPTH=12, writes to address 12 and 15 ignored -> reads of those addresses = 0x0000, and address 11 holds written 0xBEEF.

Source files
------------

// File: rtl/register_file_param_pkg.sv
// -----------------------------------------------------------------------------
// register_file_param_pkg
//   Shared constants for the parameterised register file and its storage
//   cells: default register width and depth, byte-lane width, and a
//   constant-evaluable ceiling-log2 used to size address ports.
// -----------------------------------------------------------------------------
package register_file_param_pkg;

   localparam int DATA_W_DEF = 32;   // default register width in bits
   localparam int DEPTH_DEF  = 32;   // default number of registers
   localparam int LANE_W     = 8;    // width of one byte lane

   // Ceiling log2; returns 0 for values <= 1. Usable in constant expressions.
   function automatic int clog2(input int value);
      int result;
      int remain;
      result = 0;
      remain = value - 1;
      while (remain > 0) begin
         result = result + 1;
         remain = remain >> 1;
      end
      return result;
   endfunction

endpackage : register_file_param_pkg

// File: rtl/register_nbit.sv
// -----------------------------------------------------------------------------
// register_nbit
//   One DATA_W-wide storage register with per-byte write strobes and an
//   asynchronous active-low clear.
//
//   Ports:
//     clk_i   in   1            rising-edge clock
//     rst_ni  in   1            asynchronous clear, active low
//     we_i    in   1            write enable for this register
//     strb_i  in   DATA_W/8     byte-lane strobes (bit i -> d_i[8i+7:8i])
//     d_i     in   DATA_W       write data
//     q_o     out  DATA_W       stored value
// -----------------------------------------------------------------------------
module register_nbit
   import register_file_param_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     we_i,
   input  logic [DATA_W/LANE_W-1:0] strb_i,
   input  logic [DATA_W-1:0]        d_i,
   output logic [DATA_W-1:0]        q_o
);

   localparam int LANES = DATA_W / LANE_W;

   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   // Each lane independently takes new data only when enabled and strobed.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign data_d[gi*LANE_W +: LANE_W] = (we_i && strb_i[gi])
                                              ? d_i[gi*LANE_W +: LANE_W]
                                              : data_q[gi*LANE_W +: LANE_W];
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule : register_nbit

// File: rtl/register_file_param.sv
// -----------------------------------------------------------------------------
// register_file_param
//   Parameterised register file: one byte-strobed write port, two independent
//   combinational read ports, optional hard-wired zero register and optional
//   same-cycle write-to-read forwarding.
//
//   Parameters:
//     DATA_W    register width (multiple of 8, >= 8)
//     DEPTH     number of registers (>= 2)
//     BYPASS    1 = a read of the register being written shows the merged
//               post-write value in the same cycle
//     ZERO_REG  1 = register 0 reads zero and ignores writes
//
//   Ports:
//     Clk     in   1              rising-edge clock
//     Rst_n   in   1              asynchronous clear, active low
//     WE      in   1              write enable
//     WAddr   in   clog2(DEPTH)   write address
//     WData   in   DATA_W         write data
//     WStrb   in   DATA_W/8       byte-lane write strobes
//     RAddr1  in   clog2(DEPTH)   read port 1 address
//     RAddr2  in   clog2(DEPTH)   read port 2 address
//     RData1  out  DATA_W         read port 1 data
//     RData2  out  DATA_W         read port 2 data
// -----------------------------------------------------------------------------
module register_file_param
   import register_file_param_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                     Clk,
   input  logic                     Rst_n,
   input  logic                     WE,
   input  logic [clog2(DEPTH)-1:0]  WAddr,
   input  logic [DATA_W-1:0]        WData,
   input  logic [DATA_W/LANE_W-1:0] WStrb,
   input  logic [clog2(DEPTH)-1:0]  RAddr1,
   input  logic [clog2(DEPTH)-1:0]  RAddr2,
   output logic [DATA_W-1:0]        RData1,
   output logic [DATA_W-1:0]        RData2
);

   localparam int ADDR_W = clog2(DEPTH);
   localparam int LANES  = DATA_W / LANE_W;
   // The address space is padded up to a power of two so that every address
   // value indexes a defined slot; unused slots are tied to zero, which is
   // what out-of-range reads must return anyway.
   localparam int SLOTS  = 1 << ADDR_W;
   localparam int FIRST  = (ZERO_REG != 0) ? 1 : 0;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [SLOTS];
   logic              waddr_in_range;
   logic              waddr_writable;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_old;
   logic [DATA_W-1:0] wr_merged;
   logic [DATA_W-1:0] rdata1_d;
   logic [DATA_W-1:0] rdata2_d;

   // ---------------------------------------------------------------------
   // Write decode
   // ---------------------------------------------------------------------
   assign waddr_in_range = ({1'b0, WAddr} < DEPTH_L);
   assign waddr_writable = waddr_in_range && !((ZERO_REG != 0) && (WAddr == '0));
   // Qualifying with Rst_n keeps the forwarding path quiet while reset is
   // held, so the read ports show the cleared storage only.
   assign wr_valid       = Rst_n && WE && waddr_writable;

   // ---------------------------------------------------------------------
   // Storage array: one register_nbit per writable address
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
         if ((gi < FIRST) || (gi >= DEPTH)) begin : g_const_zero
            assign mem_q[gi] = '0;
         end else begin : g_reg
            logic row_we;
            assign row_we = wr_valid && (WAddr == ADDR_W'(gi));

            register_nbit #(
               .DATA_W (DATA_W)
            ) u_reg (
               .clk_i  (Clk),
               .rst_ni (Rst_n),
               .we_i   (row_we),
               .strb_i (WStrb),
               .d_i    (WData),
               .q_o    (mem_q[gi])
            );
         end
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Bypass merge: the value the write target will hold after the edge
   // ---------------------------------------------------------------------
   assign wr_old = mem_q[WAddr];

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_merge
         assign wr_merged[gi*LANE_W +: LANE_W] = WStrb[gi]
                                                 ? WData[gi*LANE_W +: LANE_W]
                                                 : wr_old[gi*LANE_W +: LANE_W];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Read muxes. Zero register and out-of-range reads need no special case
   // here: their slots are constant zero and wr_valid is never set for them.
   // ---------------------------------------------------------------------
   always_comb begin
      rdata1_d = mem_q[RAddr1];
      rdata2_d = mem_q[RAddr2];
      if ((BYPASS != 0) && wr_valid && (RAddr1 == WAddr)) begin
         rdata1_d = wr_merged;
      end
      if ((BYPASS != 0) && wr_valid && (RAddr2 == WAddr)) begin
         rdata2_d = wr_merged;
      end
   end

   assign RData1 = rdata1_d;
   assign RData2 = rdata2_d;

endmodule : register_file_param

// File: tb/tb_register_file_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_register_file_param
//   Directed bench for register_file_param. Three instances: default
//   configuration, BYPASS=0, and DATA_W=16/DEPTH=12. The 32-bit pair share
//   their inputs so forwarding and non-forwarding behaviour are compared on
//   identical stimulus.
// -----------------------------------------------------------------------------
module tb_register_file_param;

   logic        Clk;
   logic        Rst_n;
   logic        WE;
   logic [4:0]  WAddr;
   logic [31:0] WData;
   logic [3:0]  WStrb;
   logic [4:0]  RAddr1;
   logic [4:0]  RAddr2;
   logic [31:0] rd1_byp, rd2_byp, rd1_nb, rd2_nb;

   logic        we16;
   logic [3:0]  waddr16;
   logic [15:0] wdata16;
   logic [1:0]  wstrb16;
   logic [3:0]  raddr16_1, raddr16_2;
   logic [15:0] rd16_1, rd16_2;

   int checks;
   int errors;

   register_file_param #(.DATA_W(32), .DEPTH(32), .BYPASS(1), .ZERO_REG(1)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .WE(WE), .WAddr(WAddr), .WData(WData),
      .WStrb(WStrb), .RAddr1(RAddr1), .RAddr2(RAddr2),
      .RData1(rd1_byp), .RData2(rd2_byp)
   );

   register_file_param #(.DATA_W(32), .DEPTH(32), .BYPASS(0), .ZERO_REG(1)) dut_nb (
      .Clk(Clk), .Rst_n(Rst_n), .WE(WE), .WAddr(WAddr), .WData(WData),
      .WStrb(WStrb), .RAddr1(RAddr1), .RAddr2(RAddr2),
      .RData1(rd1_nb), .RData2(rd2_nb)
   );

   register_file_param #(.DATA_W(16), .DEPTH(12), .BYPASS(1), .ZERO_REG(1)) dut16 (
      .Clk(Clk), .Rst_n(Rst_n), .WE(we16), .WAddr(waddr16), .WData(wdata16),
      .WStrb(wstrb16), .RAddr1(raddr16_1), .RAddr2(raddr16_2),
      .RData1(rd16_1), .RData2(rd16_2)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] e1;   // same-cycle RData1, BYPASS=1
      logic [31:0] e2;   // same-cycle RData2, BYPASS=1
      logic [31:0] n1;   // same-cycle RData1, BYPASS=0
      logic [31:0] n2;   // same-cycle RData2, BYPASS=0
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs[NVEC];

   initial begin
      checks = 0;
      errors = 0;

      //            we    waddr  wdata         strb     ra1    ra2    e1            e2            n1            n2
      vecs[0]  = '{1'b1, 5'd5,  32'hFFFFFFFF, 4'b1111, 5'd5,  5'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
      vecs[1]  = '{1'b1, 5'd5,  32'h12345678, 4'b0101, 5'd5,  5'd0,  32'hFF34FF78, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
      vecs[2]  = '{1'b0, 5'd0,  32'h00000000, 4'b0000, 5'd5,  5'd5,  32'hFF34FF78, 32'hFF34FF78, 32'hFF34FF78, 32'hFF34FF78};
      vecs[3]  = '{1'b1, 5'd0,  32'hDEADBEEF, 4'b1111, 5'd0,  5'd5,  32'h00000000, 32'hFF34FF78, 32'h00000000, 32'hFF34FF78};
      vecs[4]  = '{1'b0, 5'd0,  32'h00000000, 4'b0000, 5'd0,  5'd0,  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
      vecs[5]  = '{1'b1, 5'd7,  32'hAAAAAAAA, 4'b1111, 5'd5,  5'd1,  32'hFF34FF78, 32'h00000000, 32'hFF34FF78, 32'h00000000};
      vecs[6]  = '{1'b1, 5'd7,  32'h0000F0F0, 4'b0011, 5'd5,  5'd7,  32'hFF34FF78, 32'hAAAAF0F0, 32'hFF34FF78, 32'hAAAAAAAA};
      vecs[7]  = '{1'b0, 5'd0,  32'h00000000, 4'b0000, 5'd7,  5'd7,  32'hAAAAF0F0, 32'hAAAAF0F0, 32'hAAAAF0F0, 32'hAAAAF0F0};
      vecs[8]  = '{1'b1, 5'd7,  32'h12345678, 4'b0000, 5'd7,  5'd7,  32'hAAAAF0F0, 32'hAAAAF0F0, 32'hAAAAF0F0, 32'hAAAAF0F0};
      vecs[9]  = '{1'b1, 5'd31, 32'h0BADF00D, 4'b1000, 5'd31, 5'd7,  32'h0B000000, 32'hAAAAF0F0, 32'h00000000, 32'hAAAAF0F0};
      vecs[10] = '{1'b1, 5'd31, 32'h11223344, 4'b1100, 5'd31, 5'd31, 32'h11220000, 32'h11220000, 32'h0B000000, 32'h0B000000};
      vecs[11] = '{1'b1, 5'd31, 32'h55667788, 4'b0110, 5'd31, 5'd2,  32'h11667700, 32'h00000000, 32'h11220000, 32'h00000000};
      vecs[12] = '{1'b0, 5'd0,  32'h00000000, 4'b0000, 5'd31, 5'd31, 32'h11667700, 32'h11667700, 32'h11667700, 32'h11667700};

      // ---------------- reset ----------------
      Rst_n  = 1'b0;
      WE     = 1'b1;  WAddr = 5'd5; WData = 32'hFFFFFFFF; WStrb = 4'hF;
      RAddr1 = 5'd5;  RAddr2 = 5'd5;
      we16   = 1'b0;  waddr16 = '0; wdata16 = '0; wstrb16 = '0;
      raddr16_1 = '0; raddr16_2 = '0;
      #1;
      chk("reset_write_ignored_byp_rd1", rd1_byp, 32'h0);
      chk("reset_write_ignored_nb_rd2", rd2_nb, 32'h0);
      $display("reset held: WE=1 to addr 5, rd1_byp=%h rd2_nb=%h", rd1_byp, rd2_nb);
      #2;
      WE    = 1'b0;
      Rst_n = 1'b1;
      for (int a = 0; a < 32; a++) begin
         RAddr1 = 5'(a);
         RAddr2 = 5'(31 - a);
         raddr16_1 = 4'(a);
         #0.2;
         chk($sformatf("reset_rd1_a%0d", a), rd1_byp, 32'h0);
         chk($sformatf("reset_rd2_a%0d", 31 - a), rd2_byp, 32'h0);
         if (a < 16) chk($sformatf("reset_rd16_a%0d", a), {16'h0, rd16_1}, 32'h0);
         $display("reset read a=%0d: rd1=%h rd2=%h", a, rd1_byp, rd2_byp);
      end

      // ---------------- table vectors ----------------
      for (int i = 0; i < NVEC; i++) begin
         @(negedge Clk);
         WE = vecs[i].we; WAddr = vecs[i].waddr; WData = vecs[i].wdata;
         WStrb = vecs[i].wstrb; RAddr1 = vecs[i].ra1; RAddr2 = vecs[i].ra2;
         #1;
         chk($sformatf("vec%0d_byp_rd1", i), rd1_byp, vecs[i].e1);
         chk($sformatf("vec%0d_byp_rd2", i), rd2_byp, vecs[i].e2);
         chk($sformatf("vec%0d_nb_rd1", i), rd1_nb, vecs[i].n1);
         chk($sformatf("vec%0d_nb_rd2", i), rd2_nb, vecs[i].n2);
         $display("vec %0d: we=%0b waddr=%0d wdata=%h strb=%b ra1=%0d ra2=%0d | byp %h %h | nb %h %h",
                  i, WE, WAddr, WData, WStrb, RAddr1, RAddr2, rd1_byp, rd2_byp, rd1_nb, rd2_nb);
      end

      // ---------------- async reset pulse between edges ----------------
      @(negedge Clk);
      WE = 1'b1; WAddr = 5'd3; WData = 32'h11111111; WStrb = 4'hF;
      @(negedge Clk);
      WE = 1'b0; RAddr1 = 5'd3; RAddr2 = 5'd31;
      #1;
      chk("r3_loaded", rd1_nb, 32'h11111111);
      Rst_n = 1'b0;
      #1;
      chk("async_clear_rd1", rd1_byp, 32'h0);
      chk("async_clear_nb_rd1", rd1_nb, 32'h0);
      Rst_n = 1'b1;
      #1;
      chk("cleared_after_pulse_r3", rd1_byp, 32'h0);
      chk("cleared_after_pulse_r31", rd2_nb, 32'h0);
      $display("reset pulse between edges: r3=%h r31=%h", rd1_byp, rd2_nb);

      // ---------------- reset asserted mid-write ----------------
      @(negedge Clk);
      WE = 1'b1; WAddr = 5'd3; WData = 32'h33333333; WStrb = 4'hF; RAddr1 = 5'd3;
      #1;
      chk("midwrite_bypass_before_reset", rd1_byp, 32'h33333333);
      Rst_n = 1'b0;
      #1;
      chk("midwrite_bypass_in_reset", rd1_byp, 32'h0);
      @(posedge Clk);
      #1;
      chk("midwrite_not_stored", rd1_nb, 32'h0);
      @(negedge Clk);
      WData = 32'h22222222;
      Rst_n = 1'b1;
      #1;
      chk("release_bypass_byp", rd1_byp, 32'h22222222);
      chk("release_bypass_nb", rd1_nb, 32'h0);
      @(negedge Clk);
      WE = 1'b0; RAddr2 = 5'd5;
      #1;
      chk("first_write_after_release_byp", rd1_byp, 32'h22222222);
      chk("first_write_after_release_nb", rd1_nb, 32'h22222222);
      chk("r5_cleared_by_reset", rd2_byp, 32'h0);
      $display("after release: r3=%h r5=%h", rd1_byp, rd2_byp);

      // ---------------- DATA_W=16, DEPTH=12 ----------------
      @(negedge Clk);
      we16 = 1'b1; waddr16 = 4'd12; wdata16 = 16'h1234; wstrb16 = 2'b11;
      raddr16_1 = 4'd12; raddr16_2 = 4'd11;
      #1;
      chk("w16_a12_no_bypass", {16'h0, rd16_1}, 32'h0);
      $display("w16 write a=12 data=1234: rd1=%h", rd16_1);
      @(negedge Clk);
      waddr16 = 4'd15; wdata16 = 16'h5678; raddr16_1 = 4'd15;
      #1;
      chk("w16_a15_no_bypass", {16'h0, rd16_1}, 32'h0);
      $display("w16 write a=15 data=5678: rd1=%h", rd16_1);
      @(negedge Clk);
      waddr16 = 4'd11; wdata16 = 16'hBEEF; raddr16_1 = 4'd12;
      #1;
      chk("w16_a11_bypass", {16'h0, rd16_2}, 32'h0000BEEF);
      chk("w16_a12_still_zero", {16'h0, rd16_1}, 32'h0);
      $display("w16 write a=11 data=BEEF: rd1=%h rd2=%h", rd16_1, rd16_2);
      @(negedge Clk);
      we16 = 1'b0; raddr16_1 = 4'd12; raddr16_2 = 4'd15;
      #1;
      chk("w16_read_a12", {16'h0, rd16_1}, 32'h0);
      chk("w16_read_a15", {16'h0, rd16_2}, 32'h0);
      raddr16_1 = 4'd11; raddr16_2 = 4'd11;
      #1;
      chk("w16_read_a11_p1", {16'h0, rd16_1}, 32'h0000BEEF);
      chk("w16_read_a11_p2", {16'h0, rd16_2}, 32'h0000BEEF);
      $display("w16 read a=11: rd1=%h rd2=%h", rd16_1, rd16_2);
      @(negedge Clk);
      we16 = 1'b1; waddr16 = 4'd11; wdata16 = 16'h00AA; wstrb16 = 2'b01;
      @(negedge Clk);
      we16 = 1'b0;
      #1;
      chk("w16_partial_strobe", {16'h0, rd16_1}, 32'h0000BEAA);
      $display("w16 strobe 01 data=00AA to a=11: rd1=%h", rd16_1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_register_file_param
